// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: LC3 memory-mapped UART with TX/RX FIFOs, programmable bit period,
// runtime parity and sticky overrun/framing/parity flags.
module uart_mmio_fifo #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] MDR,
    input  logic        LD_UARTDR,
    input  logic        LD_UARTSR,
    input  logic        RD_UARTDR,
    input  logic        rxd,
    output logic        txd,
    output logic [15:0] UARTDR,
    output logic [15:0] UARTSR,
    output logic        WR
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int CW  = $clog2(CLK_DIV);
    localparam int BW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp;
    logic [RAW:0] rx_wp, rx_rp;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop, sr_wr;
    logic par_en, par_odd, ov, fe, pe;
    tx_state_t ts, ts_n;
    logic [CW-1:0] tcnt;
    logic [BW-1:0] tbit;
    logic [DATA_BITS-1:0] tsh, tx_head;
    logic tpe, tpar, t_tick;
    rx_state_t rs, rs_n;
    logic [CW-1:0] rcnt;
    logic [BW-1:0] rbit;
    logic [DATA_BITS-1:0] rsh;
    logic s1, s2, s3, rpe, rodd, rbad, r_tick, r_half, r_done, good;
    logic unused_mdr;

    assign unused_mdr = ^{MDR[15:14], MDR[10:DATA_BITS]};
    assign tx_full  = (tx_wp ^ tx_rp) == {1'b1, {TAW{1'b0}}};
    assign tx_empty = tx_wp == tx_rp;
    assign rx_full  = (rx_wp ^ rx_rp) == {1'b1, {RAW{1'b0}}};
    assign rx_empty = rx_wp == rx_rp;
    assign sr_wr    = LD_UARTSR && !LD_UARTDR;
    assign tx_push  = LD_UARTDR && !tx_full;
    assign tx_head  = tx_mem[tx_rp[TAW-1:0]];
    assign t_tick   = tcnt == CW'(CLK_DIV - 1);

    always_comb begin
        ts_n = ts;
        tx_pop = 1'b0;
        case (ts)
            T_IDLE:  if (!tx_empty) begin ts_n = T_START; tx_pop = 1'b1; end
            T_START: if (t_tick) ts_n = T_DATA;
            T_DATA:  if (t_tick && tbit == BW'(DATA_BITS - 1)) ts_n = tpe ? T_PAR : T_STOP;
            T_PAR:   if (t_tick) ts_n = T_STOP;
            // chain straight into the next start bit so back-to-back frames have no gap
            T_STOP:  if (t_tick) begin ts_n = tx_empty ? T_IDLE : T_START; tx_pop = !tx_empty; end
            default: ts_n = T_IDLE;
        endcase
    end

    assign txd = ts == T_START ? 1'b0 : ts == T_DATA ? tsh[0] : ts == T_PAR ? tpar : 1'b1;

    assign r_tick = rcnt == CW'(CLK_DIV - 1);
    assign r_half = rcnt == CW'(CLK_DIV / 2 - 1);

    always_comb begin
        rs_n = rs;
        case (rs)
            R_IDLE:  if (s3 && !s2) rs_n = R_START;
            R_START: if (r_half) rs_n = s2 ? R_IDLE : R_DATA;
            R_DATA:  if (r_tick && rbit == BW'(DATA_BITS - 1)) rs_n = rpe ? R_PAR : R_STOP;
            R_PAR:   if (r_tick) rs_n = R_STOP;
            R_STOP:  if (r_tick) rs_n = R_IDLE;
            default: rs_n = R_IDLE;
        endcase
    end

    assign r_done  = rs == R_STOP && r_tick;
    assign good    = r_done && s2 && !rbad;
    assign rx_pop  = RD_UARTDR && !rx_empty;
    assign rx_push = good && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= MDR[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rsh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
            par_en <= 1'b0; par_odd <= 1'b0; ov <= 1'b0; fe <= 1'b0; pe <= 1'b0; WR <= 1'b0;
            ts <= T_IDLE; tcnt <= '0; tbit <= '0; tsh <= '0; tpe <= 1'b0; tpar <= 1'b0;
            rs <= R_IDLE; rcnt <= '0; rbit <= '0; rsh <= '0; rpe <= 1'b0; rodd <= 1'b0; rbad <= 1'b0;
            s1 <= 1'b1; s2 <= 1'b1; s3 <= 1'b1;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            WR <= LD_UARTDR ? tx_push : LD_UARTSR;
            if (sr_wr) {par_en, par_odd} <= MDR[1:0];
            // a flag raised in the same cycle as its clear stays set
            ov <= (good && rx_full && !rx_pop) || (ov && !(sr_wr && MDR[13]));
            fe <= (r_done && !s2) || (fe && !(sr_wr && MDR[12]));
            pe <= (r_done && s2 && rbad) || (pe && !(sr_wr && MDR[11]));
            ts <= ts_n;
            tcnt <= (t_tick || ts == T_IDLE) ? '0 : tcnt + 1'b1;
            tbit <= ts != T_DATA ? '0 : t_tick ? tbit + 1'b1 : tbit;
            if (tx_pop) begin
                tsh <= tx_head; tpe <= par_en; tpar <= ^tx_head ^ par_odd;
            end else if (ts == T_DATA && t_tick) tsh <= tsh >> 1;
            s1 <= rxd; s2 <= s1; s3 <= s2;
            rs <= rs_n;
            rcnt <= (rs == R_IDLE || rs_n != rs || r_tick) ? '0 : rcnt + 1'b1;
            rbit <= rs != R_DATA ? '0 : r_tick ? rbit + 1'b1 : rbit;
            if (rs == R_IDLE && rs_n == R_START) begin
                rpe <= par_en; rodd <= par_odd; rbad <= 1'b0;
            end
            if (rs == R_DATA && r_tick) rsh <= {s2, rsh[DATA_BITS-1:1]};
            if (rs == R_PAR && r_tick) rbad <= s2 != (^rsh ^ rodd);
        end
    end

    assign UARTDR = rx_empty ? '0 : 16'(rx_mem[rx_rp[RAW-1:0]]);
    assign UARTSR = {!tx_full, !rx_empty, ov, fe, pe, 9'b0, par_en, par_odd};
endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
Parametrised memory-mapped UART for the LC3 I/O page, replacing the single-buffer UART. It adds TX and RX FIFOs, a configurable bit period and data width, runtime parity control, and sticky error flags. The LC3 side sees DR and SR through the existing MDR/LD_* strobes, plus a new read strobe that pops received data.

Parameters:
CLK_DIV, 434, clocks per bit period (>=4); 50 MHz / 115200 baud
DATA_BITS, 8, payload bits per frame (5..8)
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
MDR  in  16  write data from LC3 memory data register
LD_UARTDR  in  1  write strobe: push MDR[DATA_BITS-1:0] into TX FIFO
LD_UARTSR  in  1  write strobe: update SR control bits / clear errors
RD_UARTDR  in  1  read strobe: pop RX FIFO head
rxd  in  1  serial input, asynchronous to clk
txd  out  1  serial output, idle high
UARTDR  out  16  RX FIFO head, zero-extended; 0 when RX FIFO empty
UARTSR  out  16  status/control register
WR  out  1  one-cycle write-accepted pulse

Behaviour:
- Reset (async, rst_n=0): txd=1; both FIFOs empty; both FSMs IDLE; UARTSR=16'h8000; UARTDR=0; WR=0; baud counters 0. A reset mid-frame aborts the frame immediately.
- UARTSR bits:
  - [15] TX ready = TX FIFO not full.
  - [14] RX valid = RX FIFO not empty.
  - [13] overrun, [12] framing error, [11] parity error: all sticky.
  - [1] parity_en, [0] parity_odd: R/W.
  - All other bits read 0.
- LD_UARTSR: MDR[1:0] -> SR[1:0]. Each 1 written to MDR[13:11] clears the matching flag (write-1-to-clear). If an error event and a clear hit the same cycle, the event wins.
- LD_UARTDR:
  - Push when TX FIFO not full; a write to a full FIFO is dropped.
  - WR=1 on the cycle after an accepted LD_UARTDR or any LD_UARTSR; otherwise 0.
  - If LD_UARTDR and LD_UARTSR are both high, only DR is acted on.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each state lasts exactly CLK_DIV clocks.
  - Data is sent LSB first, DATA_BITS bits.
  - The PARITY state is present only if parity_en was set when the frame started. Parity bit = XOR of data bits, inverted when parity_odd.
  - Parity config is latched at START; mid-frame SR writes affect the next frame only.
  - IDLE->START when the FIFO is non-empty; the head is popped in that same cycle.
  - Latency: push into an empty, idle TX -> txd falls 1 clock later.
  - Back-to-back frames: no idle gap beyond the single stop bit.
- RX path: rxd passes a 2-FF synchroniser (2-clock latency).
  - In IDLE, a falling edge starts a half-bit (CLK_DIV/2) count. At mid-start, if the line is high, it is a glitch: return to IDLE, no flag.
  - After a valid start, sample at the middle of each bit: DATA_BITS data, parity if enabled, then stop.
  - Stop=0: set framing error and discard the byte.
  - Parity mismatch: set parity error and discard the byte.
  - Good byte with RX FIFO full: set overrun and drop the new byte; FIFO contents are kept.
  - After the stop sample, return to IDLE at once, so the next start edge is caught.
- RD_UARTDR pops the head on that clock. A pop when empty is ignored. A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- UARTDR and UARTSR are combinational views of the FIFO head and state.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty are decided by the MSB compare.

Test Plan:
- Reset, then write DR=16'h0041 with CLK_DIV=8, 8N1 -> WR pulses one cycle; txd=0 for 8 clocks, then bits 1,0,0,0,0,0,1,0 of 8 clocks each, then stop high; SR[15] stays 1.
- Write 5 bytes back-to-back with TX_DEPTH=4, TX idle -> first pops immediately and all 5 are accepted. A 6th write while SR[15]=0 is dropped with no WR; all 5 frames go out contiguously.
- Drive a serial 0xA5 frame with even parity enabled (SR write 16'h0002) -> SR[14]=1, UARTDR=16'h00A5; RD_UARTDR -> SR[14]=0, UARTDR=0.
- Send 5 frames with no reads, RX_DEPTH=4 -> SR[13]=1 and the FIFO holds the first 4 bytes in order. Write SR with MDR=16'h2000 -> SR[13]=0.
- Send a frame with stop=0, then a 3-clock low glitch -> SR[12]=1, nothing pushed; the glitch sets no flag and RX returns to IDLE.
- Assert rst_n=0 mid-TX-frame -> txd=1 immediately, SR=16'h8000; after release, a new DR write transmits correctly.
